// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: strips preamble/SFD from a GMII receive stream, checks FCS and length,
// forwards the payload without the FCS and keeps saturating good/bad frame counters.
module gmii_rx_framer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_sof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] frame_len,
    output logic        pre_err,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DROP, DATA} state_t;

    state_t           state;
    logic             dv_q;
    logic [7:0]       rxd_q;
    logic [2:0]       pre_cnt;
    logic [31:0]      crc;
    logic [15:0]      byte_cnt;
    logic [3:0][7:0]  dl;
    logic [2:0]       dl_cnt;
    logic             sof_pend;
    logic [31:0]      crc_next;
    logic             crc_bad;
    logic             len_bad;
    logic [1:0]       bad_inc;
    logic [16:0]      bad_sum;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign crc_next = crc_byte(crc, rxd_q);
    // Running over the FCS too leaves the fixed CRC-32 residue on a good frame
    assign crc_bad  = crc != 32'hDEBB20E3;
    assign len_bad  = (byte_cnt < 16'(MIN_LEN)) || (byte_cnt > 16'(MAX_LEN));
    assign bad_inc  = {1'b0, frame_done & ~frame_ok} + {1'b0, pre_err};
    assign bad_sum  = {1'b0, bad_cnt} + 17'(bad_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dv_q       <= 1'b0;
            rxd_q      <= '0;
            pre_cnt    <= '0;
            crc        <= 32'hFFFFFFFF;
            byte_cnt   <= '0;
            dl         <= '0;
            dl_cnt     <= '0;
            sof_pend   <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_sof     <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            frame_len  <= '0;
            pre_err    <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            dv_q       <= gmii_rx_dv;
            rxd_q      <= gmii_rxd;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            frame_done <= 1'b0;
            pre_err    <= 1'b0;
            // Counters follow the registered status strobes one cycle later
            good_cnt   <= good_cnt + 16'(frame_done & frame_ok & ~&good_cnt);
            bad_cnt    <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
            case (state)
                IDLE: begin
                    if (dv_q && rxd_q == 8'h55) begin
                        state   <= PREAMBLE;
                        pre_cnt <= 3'd1;
                    end else if (dv_q) begin
                        pre_err <= 1'b1;
                        state   <= DROP;
                    end
                end
                PREAMBLE: begin
                    if (!dv_q) begin
                        pre_err <= 1'b1;
                        state   <= IDLE;
                    end else if (rxd_q == 8'hD5) begin
                        state    <= DATA;
                        crc      <= 32'hFFFFFFFF;
                        byte_cnt <= '0;
                        dl_cnt   <= '0;
                        sof_pend <= 1'b1;
                    end else if (rxd_q == 8'h55 && pre_cnt < 3'd7) begin
                        pre_cnt <= pre_cnt + 3'd1;
                    end else begin
                        pre_err <= 1'b1;
                        state   <= DROP;
                    end
                end
                DROP: begin
                    if (!dv_q)
                        state <= IDLE;
                end
                DATA: begin
                    if (dv_q) begin
                        crc      <= crc_next;
                        byte_cnt <= (&byte_cnt) ? byte_cnt : byte_cnt + 16'd1;
                        dl       <= {dl[2:0], rxd_q};
                        // Holding back 4 bytes keeps the FCS from ever reaching the output
                        if (dl_cnt == 3'd4) begin
                            rx_valid <= 1'b1;
                            rx_data  <= dl[3];
                            rx_sof   <= sof_pend;
                            sof_pend <= 1'b0;
                        end else begin
                            dl_cnt <= dl_cnt + 3'd1;
                        end
                    end else begin
                        frame_done <= 1'b1;
                        frame_len  <= (byte_cnt < 16'd4) ? '0 : byte_cnt - 16'd4;
                        crc_err    <= crc_bad;
                        len_err    <= len_bad;
                        frame_ok   <= ~crc_bad & ~len_bad;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb_gmii_rx_framer: randomized frames checked against a byte-level reference model
// that parses each dv burst directly from the framing rules.
module tb_gmii_rx_framer;
    typedef logic [7:0] bq_t[$];
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = '0;
    logic        rx_valid, rx_sof, frame_done, frame_ok, crc_err, len_err, pre_err;
    logic [7:0]  rx_data;
    logic [15:0] frame_len, good_cnt, bad_cnt;

    int n_vec = 0, n_err = 0;
    bq_t got_q, exp_q;
    int done_n, ok_n, sof_n, pre_n;
    logic st_ok, st_crc, st_len;
    logic [15:0] st_flen;
    int exp_pre, exp_done;
    logic exp_ok, exp_crc, exp_len;
    logic [15:0] exp_flen;
    int exp_good = 0, exp_bad = 0;

    gmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof),
        .frame_done(frame_done), .frame_ok(frame_ok), .crc_err(crc_err),
        .len_err(len_err), .frame_len(frame_len), .pre_err(pre_err),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) got_q.push_back(rx_data);
            if (rx_sof) sof_n++;
            if (pre_err) pre_n++;
            if (frame_done) begin
                done_n++;
                if (frame_ok) ok_n++;
                st_ok = frame_ok; st_crc = crc_err; st_len = len_err; st_flen = frame_len;
            end
        end
    end

    function automatic logic [31:0] crc32(input bq_t d, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, d[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_frame(input int npay, input int npre, output bq_t f);
        bq_t p;
        logic [31:0] c;
        f = {};
        for (int i = 0; i < npay; i++) p.push_back(8'($urandom));
        c = crc32(p, npay);
        repeat (npre) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (p[i]) f.push_back(p[i]);
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    endtask

    // Expected result of one dv burst, plus saturating counter bookkeeping
    task automatic model(input bq_t b);
        int n = 0, len;
        bq_t p;
        logic [31:0] fcs;
        exp_q = {}; exp_pre = 0; exp_done = 0;
        while (n < b.size() && b[n] == 8'h55) n++;
        if (n == 0 || n > 7 || n == b.size() || b[n] != 8'hD5) begin
            exp_pre = 1;
            exp_bad = (exp_bad < 65535) ? exp_bad + 1 : 65535;
            return;
        end
        len = b.size() - n - 1;
        exp_done = 1;
        for (int i = 0; i < len - 4; i++) begin
            exp_q.push_back(b[n + 1 + i]);
            p.push_back(b[n + 1 + i]);
        end
        exp_flen = (len < 4) ? 16'd0 : 16'(len - 4);
        exp_len = (len < MIN_LEN) || (len > MAX_LEN);
        fcs = {b[n + len], b[n + len - 1], b[n + len - 2], b[n + len - 3]};
        exp_crc = (len < 4) || (fcs != crc32(p, len - 4));
        exp_ok = !exp_crc && !exp_len;
        if (exp_ok) exp_good = (exp_good < 65535) ? exp_good + 1 : 65535;
        else exp_bad = (exp_bad < 65535) ? exp_bad + 1 : 65535;
    endtask

    task automatic send(input bq_t b);
        foreach (b[i]) begin
            gmii_rx_dv = 1'b1; gmii_rxd = b[i];
            @(posedge clk); #1;
        end
        gmii_rx_dv = 1'b0; gmii_rxd = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        got_q = {}; done_n = 0; ok_n = 0; sof_n = 0; pre_n = 0;
    endtask

    function automatic int diff_cnt();
        int d = (got_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1; idle(3);
        n_vec++;
        if ({rx_valid, rx_data, rx_sof, frame_done, frame_ok, crc_err, len_err, frame_len, pre_err} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", {rx_valid, rx_data, rx_sof, frame_done, frame_ok, crc_err, len_err, frame_len, pre_err});
        end
        rst = 1'b0; idle(2);
        n_vec++;
        if ({good_cnt, bad_cnt, rx_valid, frame_done, pre_err} !== '0) begin
            n_err++; $display("FAIL reset_counters: got good=%h bad=%h expected 0", good_cnt, bad_cnt);
        end
    endtask

    task automatic test_good();
        bq_t f;
        make_frame(60, 7, f); model(f); clr(); send(f); idle(8);
        n_vec++; if (diff_cnt() != 0) begin n_err++; $display("FAIL good_payload: beats %0d expected %0d", got_q.size(), exp_q.size()); end
        n_vec++; if (sof_n != 1) begin n_err++; $display("FAIL good_sof: got %0d expected 1", sof_n); end
        n_vec++; if (done_n != 1 || st_ok !== 1'b1) begin n_err++; $display("FAIL good_done: done=%0d ok=%b expected 1,1", done_n, st_ok); end
        n_vec++; if (st_flen !== 16'd60) begin n_err++; $display("FAIL good_len: got %0d expected 60", st_flen); end
        n_vec++; if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin n_err++; $display("FAIL good_cnt: got %0d/%0d expected %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
        f[18] ^= 8'h01;
        model(f); clr(); send(f); idle(8);
        n_vec++; if (got_q.size() != 60 || diff_cnt() != 0) begin n_err++; $display("FAIL crc_payload: beats %0d expected 60", got_q.size()); end
        n_vec++; if (done_n != 1 || st_crc !== 1'b1 || st_ok !== 1'b0 || st_len !== 1'b0) begin n_err++; $display("FAIL crc_status: crc=%b ok=%b len=%b expected 1,0,0", st_crc, st_ok, st_len); end
        n_vec++; if (bad_cnt !== 16'(exp_bad) || exp_bad != 1) begin n_err++; $display("FAIL crc_badcnt: got %0d expected 1", bad_cnt); end
    endtask

    task automatic test_length();
        bq_t f;
        int pay[3] = '{20, 1515, 1514};
        for (int k = 0; k < 3; k++) begin
            make_frame(pay[k], 7, f); model(f); clr(); send(f); idle(8);
            n_vec++;
            if (done_n != 1 || st_len !== exp_len || st_crc !== 1'b0 || st_flen !== exp_flen) begin
                n_err++; $display("FAIL len_%0d: len_err=%b crc=%b flen=%0d expected %b,0,%0d", pay[k], st_len, st_crc, st_flen, exp_len, exp_flen);
            end
            n_vec++; if (diff_cnt() != 0) begin n_err++; $display("FAIL len_payload_%0d: beats %0d expected %0d", pay[k], got_q.size(), exp_q.size()); end
        end
        n_vec++; if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin n_err++; $display("FAIL len_cnt: got %0d/%0d expected %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
    endtask

    task automatic test_preamble();
        bq_t f;
        for (int k = 0; k < 3; k++) begin
            make_frame(60, (k == 1) ? 8 : 7, f);
            if (k == 0) f[2] = 8'h5D;
            if (k == 2) f[0] = 8'h5A;
            model(f); clr(); send(f); idle(8);
            n_vec++;
            if (pre_n != 1 || done_n != 0 || got_q.size() != 0) begin
                n_err++; $display("FAIL preamble_%0d: pre=%0d done=%0d beats=%0d expected 1,0,0", k, pre_n, done_n, got_q.size());
            end
            n_vec++; if (bad_cnt !== 16'(exp_bad)) begin n_err++; $display("FAIL preamble_cnt_%0d: got %0d expected %0d", k, bad_cnt, exp_bad); end
        end
    endtask

    task automatic test_back_to_back();
        bq_t f1, f2;
        make_frame(60, 7, f1); make_frame(70, 7, f2);
        model(f1); exp_q.delete();
        clr(); send(f1); idle(1); send(f2); idle(8);
        model(f2);
        foreach (f1[i]) if (i >= 8 && i < f1.size() - 4) exp_q.push_front(8'h00);
        for (int i = 0; i < 60; i++) exp_q[i] = f1[8 + i];
        n_vec++; if (diff_cnt() != 0) begin n_err++; $display("FAIL b2b_payload: beats %0d expected %0d", got_q.size(), exp_q.size()); end
        n_vec++; if (done_n != 2 || ok_n != 2 || sof_n != 2) begin n_err++; $display("FAIL b2b_status: done=%0d ok=%0d sof=%0d expected 2,2,2", done_n, ok_n, sof_n); end
        n_vec++; if (good_cnt !== 16'(exp_good)) begin n_err++; $display("FAIL b2b_goodcnt: got %0d expected %0d", good_cnt, exp_good); end
    endtask

    task automatic test_reset_mid();
        bq_t f;
        make_frame(60, 7, f); clr();
        for (int i = 0; i < 8 + 30; i++) begin
            gmii_rx_dv = 1'b1; gmii_rxd = f[i];
            @(posedge clk); #1;
        end
        rst = 1'b1; #1;
        n_vec++;
        if ({rx_valid, rx_data, rx_sof, frame_done, frame_ok, crc_err, len_err, frame_len, pre_err, good_cnt, bad_cnt} !== '0) begin
            n_err++; $display("FAIL reset_mid: valid=%b good=%0d bad=%0d expected all 0", rx_valid, good_cnt, bad_cnt);
        end
        gmii_rx_dv = 1'b0; gmii_rxd = '0; exp_good = 0; exp_bad = 0;
        idle(3); rst = 1'b0; idle(5);
        n_vec++; if (done_n != 0 || pre_n != 0) begin n_err++; $display("FAIL reset_mid_done: done=%0d pre=%0d expected 0,0", done_n, pre_n); end
        make_frame(60, 7, f); model(f); clr(); send(f); idle(8);
        n_vec++; if (done_n != 1 || st_ok !== 1'b1 || diff_cnt() != 0 || good_cnt !== 16'd1) begin n_err++; $display("FAIL reset_mid_next: done=%0d ok=%b good=%0d expected 1,1,1", done_n, st_ok, good_cnt); end
    endtask

    task automatic test_saturation();
        bq_t f;
        force dut.good_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut.good_cnt;
        exp_good = 65534;
        for (int k = 0; k < 2; k++) begin
            make_frame(60, 7, f); model(f); send(f); idle(8);
            n_vec++; if (good_cnt !== 16'(exp_good)) begin n_err++; $display("FAIL sat_%0d: got %h expected %h", k, good_cnt, 16'(exp_good)); end
        end
    endtask

    task automatic test_random();
        bq_t f;
        for (int k = 0; k < 8; k++) begin
            make_frame($urandom_range(10, 150), ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : 7, f);
            if ($urandom_range(0, 2) == 0) f[f.size() - 1 - $urandom_range(0, 8)] ^= 8'(1 << $urandom_range(0, 7));
            model(f); clr(); send(f); idle($urandom_range(8, 12));
            n_vec++;
            if (diff_cnt() != 0 || done_n != exp_done || pre_n != exp_pre) begin
                n_err++; $display("FAIL rand_%0d: beats=%0d done=%0d pre=%0d expected %0d,%0d,%0d", k, got_q.size(), done_n, pre_n, exp_q.size(), exp_done, exp_pre);
            end
            n_vec++;
            if (exp_done == 1 && (st_ok !== exp_ok || st_crc !== exp_crc || st_len !== exp_len || st_flen !== exp_flen)) begin
                n_err++; $display("FAIL rand_status_%0d: ok=%b crc=%b len=%b flen=%0d expected %b,%b,%b,%0d", k, st_ok, st_crc, st_len, st_flen, exp_ok, exp_crc, exp_len, exp_flen);
            end
            n_vec++; if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin n_err++; $display("FAIL rand_cnt_%0d: got %0d/%0d expected %0d/%0d", k, good_cnt, bad_cnt, exp_good, exp_bad); end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_good();
        test_length();
        test_preamble();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
